riscv_regfile_mp_scb: RTL and testbench

Parametrised flip-flop register file with NUM_RD combinational read ports and NUM_WR write ports. Includes a per-register busy scoreboard for long-latency writebacks such as loads and multi-cycle ALU results. The decode stage reserves a destination register, and any write port releases it on writeback. Sits in the ID stage of the core and supersedes the fixed 3-read/2-write register file.

---
 rtl/riscv_regfile_mp_scb.sv | 119 +++++++++++
 tb/tb_riscv_regfile_mp_scb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile_mp_scb.sv
// Multi-port flip-flop register file with a per-register busy scoreboard for long-latency writebacks.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module riscv_regfile_mp_scb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_RD-1:0]              rbusy_o,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_WR-1:0]              we_i,
  input  logic                           rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
  output logic                           rsv_ready_o,
  output logic [2**ADDR_WIDTH-1:0]       busy_o,
  output logic [ADDR_WIDTH:0]            outstanding_o
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_q, busy_d;
  logic [NUM_WORDS-1:0]  wrHit;
  logic [ADDR_WIDTH:0]   outstanding_q, outstanding_d;
  logic [ADDR_WIDTH:0]   relCount;
  logic                  rsvIsZero;
  logic                  rsvReady;
  logic                  rsvFire;

  always_comb begin
    wrHit = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we_i[p]) begin
        wrHit[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones, so the highest-index enabled port wins.
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      rf_d[i] = rf_q[i];
    end
    for (int p = 0; p < NUM_WR; p++) begin
      if (we_i[p]) begin
        rf_d[waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (ZERO_REG != 0) begin
      rf_d[0] = '0;
    end
  end

  // A register being written back this cycle may be re-reserved immediately.
  always_comb begin
    rsvIsZero = (ZERO_REG != 0) && (rsv_addr_i == '0);
    rsvReady  = rsvIsZero || !busy_q[rsv_addr_i] || wrHit[rsv_addr_i];
    rsvFire   = rsv_valid_i && rsvReady && !rsvIsZero;
  end

  always_comb begin
    busy_d   = busy_q & ~wrHit;
    relCount = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      relCount = relCount + (ADDR_WIDTH+1)'(busy_q[i] & wrHit[i]);
    end
    if (rsvFire) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    outstanding_d = outstanding_q - relCount + (ADDR_WIDTH+1)'(rsvFire);
  end

  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
      rbusy_o[k]                          = busy_q[raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_WRITE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (we_i[p] &&
            (waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
            !((ZERO_REG != 0) && (raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
          rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
          rbusy_o[k]                          = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        rf_q[i] <= '0;
      end
      busy_q        <= '0;
      outstanding_q <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        rf_q[i] <= rf_d[i];
      end
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign rsv_ready_o   = rsvReady;
  assign busy_o        = busy_q;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_riscv_regfile_mp_scb.sv
// Directed bench for riscv_regfile_mp_scb: table-driven vectors plus hand-written scoreboard,
// forwarding and asynchronous-reset sequences.
module tb_riscv_regfile_mp_scb;

  logic        clk;
  logic        rst_n;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        rsvValid;
  logic [4:0]  rsvAddr;
  logic        rsvReady;
  logic [31:0] busy;
  logic [5:0]  outstanding;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        rv;
    logic [4:0]  ra;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [31:0] ed2;
    logic [2:0]  erb;
    logic        erdy;
    logic [31:0] ebusy;
    logic [5:0]  eouts;
  } vec_t;

  vec_t vecs [12];

  riscv_regfile_mp_scb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .we_i          (we),
    .rsv_valid_i   (rsvValid),
    .rsv_addr_i    (rsvAddr),
    .rsv_ready_o   (rsvReady),
    .busy_o        (busy),
    .outstanding_o (outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic rv,
                       input logic [4:0] ra, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [4:0] rd2);
    we       = w;
    waddr    = {wa1, wa0};
    wdata    = {wd1, wd0};
    rsvValid = rv;
    rsvAddr  = ra;
    raddr    = {rd2, rd1, rd0};
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    drive(v.we, v.wa0, v.wa1, v.wd0, v.wd1, v.rv, v.ra, v.rd0, v.rd1, v.rd2);
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, " rdata0"}, rdata[31:0], v.ed0);
    checkOutput({tag, " rdata1"}, rdata[63:32], v.ed1);
    checkOutput({tag, " rdata2"}, rdata[95:64], v.ed2);
    checkOutput({tag, " rbusy"}, 32'(rbusy), 32'(v.erb));
    checkOutput({tag, " rsv_ready"}, 32'(rsvReady), 32'(v.erdy));
    checkOutput({tag, " busy"}, busy, v.ebusy);
    checkOutput({tag, " outstanding"}, 32'(outstanding), 32'(v.eouts));
  endtask

  initial begin
    // Each row: inputs driven, then pre-edge combinational view of the state left by earlier rows.
    vecs[0]  = '{2'b11, 5'd3, 5'd3, 32'h11111111, 32'h22222222, 1'b0, 5'd0, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0, 6'd0};
    vecs[1]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd2, 32'h22222222, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0, 6'd0};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd1, 5'd0, 5'd3, 5'd1, 32'h0, 32'h22222222, 32'h0, 3'b000, 1'b1, 32'h0, 6'd0};
    vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h22222222, 3'b001, 1'b1, 32'h2, 6'd1};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h22222222, 3'b011, 1'b1, 32'h6, 6'd2};
    vecs[5]  = '{2'b11, 5'd1, 5'd2, 32'hA1, 32'hB2, 1'b1, 5'd4, 5'd3, 5'd4, 5'd0, 32'h22222222, 32'h0, 32'h0, 3'b001, 1'b1, 32'hE, 6'd3};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 5'd1, 5'd2, 5'd4, 32'hA1, 32'hB2, 32'h0, 3'b100, 1'b0, 32'h18, 6'd2};
    vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd3, 5'd4, 5'd1, 32'h22222222, 32'h0, 32'hA1, 3'b011, 1'b0, 32'h18, 6'd2};
    vecs[8]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h33, 1'b0, 5'd4, 5'd4, 5'd1, 5'd2, 32'h0, 32'hA1, 32'hB2, 3'b001, 1'b0, 32'h18, 6'd2};
    vecs[9]  = '{2'b01, 5'd5, 5'd0, 32'h55, 32'h0, 1'b0, 5'd5, 5'd3, 5'd4, 5'd0, 32'h33, 32'h0, 32'h0, 3'b010, 1'b1, 32'h10, 6'd1};
    vecs[10] = '{2'b01, 5'd4, 5'd0, 32'h44, 32'h0, 1'b0, 5'd4, 5'd5, 5'd3, 5'd2, 32'h55, 32'h33, 32'hB2, 3'b000, 1'b1, 32'h10, 6'd1};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd5, 5'd3, 32'h44, 32'h55, 32'h33, 3'b000, 1'b1, 32'h0, 6'd0};

    rst_n = 1'b0;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd31);
    #12;
    checkOutput("reset rdata0", rdata[31:0], 32'h0);
    checkOutput("reset rbusy", 32'(rbusy), 32'h0);
    checkOutput("reset busy", busy, 32'h0);
    checkOutput("reset outstanding", 32'(outstanding), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // WAW stall on r9 resolved by a same-cycle writeback
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    #1 checkOutput("r9 first rsv_ready", 32'(rsvReady), 32'h1);
    @(posedge clk) #1;
    checkOutput("r9 busy", busy, 32'h200);
    checkOutput("r9 outstanding", 32'(outstanding), 32'h1);
    checkOutput("r9 rbusy", 32'(rbusy), 32'h1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk) #1;
      checkOutput($sformatf("r9 stall%0d rsv_ready", c), 32'(rsvReady), 32'h0);
      checkOutput($sformatf("r9 stall%0d outstanding", c), 32'(outstanding), 32'h1);
    end
    @(negedge clk);
    drive(2'b01, 5'd9, 5'd0, 32'h0000ABCD, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    #1 checkOutput("r9 release rsv_ready", 32'(rsvReady), 32'h1);
    @(posedge clk) #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    #1;
    checkOutput("r9 rereserve busy", busy, 32'h200);
    checkOutput("r9 rereserve outstanding", 32'(outstanding), 32'h1);
    checkOutput("r9 rdata", rdata[31:0], 32'h0000ABCD);
    @(negedge clk);
    drive(2'b01, 5'd9, 5'd0, 32'h0000ABCD, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    @(posedge clk) #1;
    checkOutput("r9 final busy", busy, 32'h0);
    checkOutput("r9 final outstanding", 32'(outstanding), 32'h0);

    // Reserving r0 is always accepted and leaves the scoreboard untouched
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    #1 checkOutput("r0 rsv_ready", 32'(rsvReady), 32'h1);
    @(posedge clk) #1;
    checkOutput("r0 busy", busy, 32'h0);
    checkOutput("r0 outstanding", 32'(outstanding), 32'h0);

    // Same-cycle visibility of writes, with and without forwarding
    @(negedge clk);
    drive(2'b01, 5'd12, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0, 5'd0);
    #1 checkOutput("r12 same cycle", rdata[31:0], BYPASS ? 32'h12345678 : 32'h0);
    @(posedge clk) #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd0, 5'd0);
    #1 checkOutput("r12 next cycle", rdata[31:0], 32'h12345678);
    @(negedge clk);
    drive(2'b11, 5'd13, 5'd13, 32'h1, 32'h2, 1'b0, 5'd0, 5'd13, 5'd0, 5'd0);
    #1 checkOutput("r13 same cycle", rdata[31:0], BYPASS ? 32'h2 : 32'h0);
    @(posedge clk) #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd14, 5'd13, 5'd0, 5'd0);
    #1 checkOutput("r13 next cycle", rdata[31:0], 32'h2);
    @(posedge clk) #1;
    drive(2'b01, 5'd14, 5'd0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd14, 5'd0, 5'd0);
    #1;
    checkOutput("r14 same cycle rdata", rdata[31:0], BYPASS ? 32'h77 : 32'h0);
    checkOutput("r14 same cycle rbusy", 32'(rbusy[0]), BYPASS ? 32'h0 : 32'h1);
    @(posedge clk) #1;
    checkOutput("r14 busy cleared", busy, 32'h0);

    // Asynchronous reset asserted between edges
    @(negedge clk);
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 5'd5, 5'd0, 5'd0);
    @(posedge clk) #1;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    checkOutput("pre-reset r5", rdata[31:0], 32'hDEADBEEF);
    checkOutput("pre-reset busy", busy, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset r5", rdata[31:0], 32'h0);
    checkOutput("async reset busy", busy, 32'h0);
    checkOutput("async reset outstanding", 32'(outstanding), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
